// File: rtl/elink_trig_scrub_reader.sv
// rtl/elink_trig_scrub_reader.sv - Wishbone read sweep of the trigger e-link scrubber into an {addr,data} stream
// One outstanding single-beat read at a time; ack timeouts are reported per address instead of stalling the sweep.
module elink_trig_scrub_reader #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 10,
    parameter int unsigned NUM_CH  = 12,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    output logic                     o_busy,
    output logic                     o_sweep_done,
    output logic [ADDR_W-1:0]        o_wb_addr,
    output logic                     o_wb_stb,
    input  logic [DATA_W-1:0]        i_wb_data,
    input  logic                     i_wb_ack,
    input  logic                     i_wb_stall,
    output logic [ADDR_W+DATA_W-1:0] o_word_data,
    output logic                     o_word_valid,
    input  logic                     i_word_ready,
    output logic                     o_timeout_err,
    output logic [ADDR_W-1:0]        o_err_addr,
    input  logic                     i_err_clr
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, PUSH, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CH - 1);
    localparam logic [7:0]        TMO_LAST  = 8'(TIMEOUT - 1);

    state_t                     state_q, state_d;
    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic [7:0]                 tmo_q, tmo_d;
    logic [ADDR_W+DATA_W-1:0]   word_q, word_d;
    logic                       err_q, err_d;
    logic [ADDR_W-1:0]          err_addr_q, err_addr_d;
    logic                       busy_q, busy_d;
    logic                       stb_q, stb_d;
    logic                       valid_q, valid_d;
    logic                       done_q, done_d;
    logic                       timeout_hit;
    logic                       advance;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        tmo_d       = tmo_q;
        word_d      = word_q;
        err_d       = err_q;
        err_addr_d  = err_addr_q;
        timeout_hit = 1'b0;
        advance     = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    addr_d  = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!i_wb_stall) begin
                    if (i_wb_ack) begin
                        word_d  = {addr_q, i_wb_data};
                        state_d = PUSH;
                    end else begin
                        tmo_d   = '0;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                tmo_d = tmo_q + 8'd1;
                if (i_wb_ack) begin
                    word_d  = {addr_q, i_wb_data};
                    state_d = PUSH;
                end else if (tmo_q == TMO_LAST) begin
                    timeout_hit = 1'b1;
                    advance     = 1'b1;
                end
            end
            PUSH: begin
                if (i_word_ready) begin
                    advance = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (advance) begin
            if (addr_q == LAST_ADDR) begin
                state_d = DONE;
            end else begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = REQ;
            end
        end

        // A timeout landing in the same cycle as a clear must survive it.
        if (timeout_hit) begin
            err_d      = 1'b1;
            err_addr_d = addr_q;
        end else if (i_err_clr) begin
            err_d      = 1'b0;
            err_addr_d = '0;
        end

        busy_d  = (state_d == REQ) || (state_d == WAIT) || (state_d == PUSH);
        stb_d   = (state_d == REQ);
        valid_d = (state_d == PUSH);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            tmo_q      <= '0;
            word_q     <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            busy_q     <= 1'b0;
            stb_q      <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            tmo_q      <= tmo_d;
            word_q     <= word_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            busy_q     <= busy_d;
            stb_q      <= stb_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
        end
    end

    assign o_busy        = busy_q;
    assign o_sweep_done  = done_q;
    assign o_wb_addr     = addr_q;
    assign o_wb_stb      = stb_q;
    assign o_word_data   = word_q;
    assign o_word_valid  = valid_q;
    assign o_timeout_err = err_q;
    assign o_err_addr    = err_addr_q;

endmodule

// File: tb/tb_elink_trig_scrub_reader.sv
// tb/tb_elink_trig_scrub_reader.sv - table-driven sweep scenarios plus reset-abort sequence
module tb_elink_trig_scrub_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        o_busy;
    logic        o_sweep_done;
    logic [3:0]  o_wb_addr;
    logic        o_wb_stb;
    logic [9:0]  i_wb_data = '0;
    logic        i_wb_ack = 1'b0;
    logic        i_wb_stall = 1'b0;
    logic [13:0] o_word_data;
    logic        o_word_valid;
    logic        i_word_ready = 1'b1;
    logic        o_timeout_err;
    logic [3:0]  o_err_addr;
    logic        i_err_clr = 1'b0;

    elink_trig_scrub_reader #(.ADDR_W(4), .DATA_W(10), .NUM_CH(12), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .o_busy(o_busy),
        .o_sweep_done(o_sweep_done), .o_wb_addr(o_wb_addr), .o_wb_stb(o_wb_stb),
        .i_wb_data(i_wb_data), .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall),
        .o_word_data(o_word_data), .o_word_valid(o_word_valid), .i_word_ready(i_word_ready),
        .o_timeout_err(o_timeout_err), .o_err_addr(o_err_addr), .i_err_clr(i_err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          late;       // 1: ack one cycle after acceptance, 0: ack with acceptance
        logic [11:0] noack;      // addresses the slave never acks
        int          stall_addr;
        int          stall_n;
        int          rdy_addr;
        int          rdy_n;
        int          clr_cyc;
        int          start_cyc;
        int          exp_cycles;
        int          exp_stb;
        int          exp_err;
        int          exp_err_addr;
        string       name;
    } vec_t;

    vec_t        vecs[10];
    vec_t        cur;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          stall_left;
    int          rdy_left;
    int          stb_cnt;
    logic        acc_prev = 1'b0;
    logic [3:0]  acc_addr = '0;
    logic [13:0] got[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Advance to the next falling edge, then act as slave and downstream sink for that cycle.
    task automatic step();
        logic       ack;
        logic [9:0] d;
        logic       stl;
        logic       rdy;
        @(negedge clk);
        ack = 1'b0; d = 10'h3FF; stl = 1'b0; rdy = 1'b1;
        if (!rst_n) begin
            acc_prev = 1'b0;
        end else begin
            if (cur.late != 0 && acc_prev && !cur.noack[acc_addr]) begin
                ack = 1'b1; d = 10'h200 | 10'(acc_addr);
            end
            if (o_wb_stb && 32'(o_wb_addr) == cur.stall_addr && stall_left > 0) begin
                stl = 1'b1; stall_left--;
            end
            if (cur.late == 0 && o_wb_stb && !stl && !cur.noack[o_wb_addr]) begin
                ack = 1'b1; d = 10'h200 | 10'(o_wb_addr);
            end
            acc_prev = o_wb_stb && !stl;
            acc_addr = o_wb_addr;
            if (o_word_valid && 32'(o_word_data[13:10]) == cur.rdy_addr && rdy_left > 0) begin
                rdy = 1'b0; rdy_left--;
            end
            if (o_word_valid && rdy) got.push_back(o_word_data);
            if (o_wb_stb) stb_cnt++;
        end
        i_wb_ack = ack; i_wb_data = d; i_wb_stall = stl; i_word_ready = rdy;
    endtask

    task automatic run_sweep(input int v);
        int          cyc;
        logic        done;
        int          k;
        logic [13:0] exp_w;
        cur = vecs[v];
        stall_left = cur.stall_n;
        rdy_left = cur.rdy_n;
        i_err_clr = 1'b1; step(); i_err_clr = 1'b0; step();
        got.delete(); stb_cnt = 0;
        i_start = 1'b1; step(); i_start = 1'b0;
        chk({cur.name, "_first_req"}, 32'({o_busy, o_wb_stb, o_wb_addr}), 32'b110000);
        cyc = 0; done = 1'b0;
        while (!done && cyc < 500) begin
            i_err_clr = (cyc == cur.clr_cyc);
            i_start   = (cyc == cur.start_cyc);
            step();
            cyc++;
            if (o_sweep_done) done = 1'b1;
        end
        i_err_clr = 1'b0; i_start = 1'b0;
        chk({cur.name, "_done_seen"}, 32'(done), 32'd1);
        chk({cur.name, "_cycles"}, 32'(cyc), 32'(cur.exp_cycles));
        chk({cur.name, "_busy_in_done"}, 32'(o_busy), 32'd0);
        chk({cur.name, "_stb_cycles"}, 32'(stb_cnt), 32'(cur.exp_stb));
        chk({cur.name, "_err"}, 32'(o_timeout_err), 32'(cur.exp_err));
        chk({cur.name, "_err_addr"}, 32'(o_err_addr), 32'(cur.exp_err_addr));
        step();
        chk({cur.name, "_idle_after"}, 32'({o_sweep_done, o_busy, o_wb_stb, o_word_valid}), 32'd0);
        chk({cur.name, "_word_count"}, 32'(got.size()), 32'(12 - $countones(cur.noack)));
        k = 0;
        for (int a = 0; a < 12; a++) begin
            if (!cur.noack[a]) begin
                exp_w = {4'(a), 10'h200 | 10'(a)};
                if (k < got.size()) chk($sformatf("%s_word%0d", cur.name, a), 32'(got[k]), 32'(exp_w));
                k++;
            end
        end
    endtask

    initial begin
        int anyact;
        //          late noack    st_a st_n rd_a rd_n clr start cyc stb err eaddr
        vecs[0] = '{1, 12'h000,   0,   0,   0,   0,   -1,  -1,  36, 12, 0, 0,  "nominal"};
        vecs[1] = '{0, 12'h000,   0,   0,   0,   0,   -1,  -1,  24, 12, 0, 0,  "same_ack"};
        vecs[2] = '{1, 12'h000,   3,   5,   0,   0,   -1,  -1,  41, 17, 0, 0,  "stall3"};
        vecs[3] = '{1, 12'h080,   0,   0,   0,   0,   -1,  -1,  49, 12, 1, 7,  "tmo7"};
        vecs[4] = '{1, 12'h000,   0,   0,   0,   4,   -1,  -1,  40, 12, 0, 0,  "bp0"};
        vecs[5] = '{1, 12'h800,   0,   0,   0,   0,   -1,  -1,  49, 12, 1, 11, "tmo_last"};
        vecs[6] = '{1, 12'h202,   0,   0,   0,   0,   -1,  -1,  62, 12, 1, 9,  "tmo_1_9"};
        vecs[7] = '{1, 12'h004,   0,   0,   0,   0,   28,  25,  49, 12, 0, 0,  "clr_restart"};
        vecs[8] = '{1, 12'h004,   0,   0,   0,   0,   21,  -1,  49, 12, 1, 2,  "clr_vs_tmo"};
        vecs[9] = '{0, 12'h000,   0,   3,   0,   0,   -1,  -1,  27, 15, 0, 0,  "same_stall0"};
        cur = vecs[0];
        stall_left = 0; rdy_left = 0; stb_cnt = 0;

        step(); step();
        chk("reset_ctrl", 32'({o_busy, o_sweep_done, o_wb_stb, o_word_valid, o_timeout_err}), 32'd0);
        chk("reset_data", 32'({o_wb_addr, o_err_addr, o_word_data}), 32'd0);
        rst_n = 1'b1;
        step(); step();
        chk("idle_no_start", 32'({o_busy, o_wb_stb, o_word_valid}), 32'd0);

        for (int v = 0; v < 10; v++) run_sweep(v);

        cur = vecs[0]; stall_left = 0; rdy_left = 0; got.delete();
        i_start = 1'b1; step(); i_start = 1'b0;
        for (int c = 0; c < 16; c++) step();
        chk("abort_in_wait5", 32'({o_busy, o_wb_stb, o_wb_addr}), 32'b100101);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_async_ctrl", 32'({o_busy, o_sweep_done, o_wb_stb, o_word_valid, o_timeout_err}), 32'd0);
        chk("abort_async_data", 32'({o_wb_addr, o_err_addr, o_word_data}), 32'd0);
        step(); step();
        rst_n = 1'b1;
        got.delete();
        anyact = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            anyact = anyact | int'({o_busy, o_wb_stb, o_word_valid, o_sweep_done});
        end
        chk("abort_stays_idle", 32'(anyact), 32'd0);
        chk("abort_no_words", 32'(got.size()), 32'd0);
        run_sweep(0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/elink_trig_scrub_reader.md
# elink_trig_scrub_reader

Wishbone read initiator that drains the trigger e-link scrubber. On a start pulse it sweeps scrubber addresses 0..NUM_CH-1 and issues one single-beat read per address, with one transaction outstanding at a time. It tags each returned 10-bit word with its address and hands it downstream over a valid/ready stream. The block sits between the scrubber's Wishbone slave port and the trigger-primitive packer, and reports per-address ack timeouts.

## Interface
- ADDR_W, 4, Wishbone address width
- DATA_W, 10, Wishbone read-data width
- NUM_CH, 12, addresses read per sweep; legal range 1..2**ADDR_W
- TIMEOUT, 15, max cycles waited for ack after the request is accepted; legal range 1..255

- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle sweep request; ignored while o_busy=1
- o_busy  out  1  high from the cycle after an accepted i_start until o_sweep_done
- o_sweep_done  out  1  one-cycle pulse after the last address completes
- o_wb_addr  out  ADDR_W  read address; stable while o_wb_stb=1
- o_wb_stb  out  1  request strobe
- i_wb_data  in  DATA_W  read data; valid only when i_wb_ack=1
- i_wb_ack  in  1  slave acknowledge
- i_wb_stall  in  1  slave not accepting; request is held
- o_word_data  out  ADDR_W+DATA_W  {address, data}
- o_word_valid  out  1  downstream word valid
- i_word_ready  in  1  downstream accept
- o_timeout_err  out  1  sticky; set on any ack timeout
- o_err_addr  out  ADDR_W  address of the most recent timeout
- i_err_clr  in  1  clears o_timeout_err and o_err_addr

## Operation
- Reset: all outputs 0; FSM to IDLE; address counter 0; timeout counter 0. Asserting rst_n low mid-sweep aborts the sweep. After release, no word is emitted until a new i_start.
- FSM states: IDLE, REQ, WAIT, PUSH, DONE.
- IDLE: on i_start=1, load addr=0 and enter REQ.
- REQ: o_wb_stb=1, o_wb_addr=addr.
  - Request is accepted on the first cycle with i_wb_stall=0.
  - Accepted with i_wb_ack=1 in the same cycle: capture data and go to PUSH.
  - Accepted without ack: go to WAIT with the timeout counter cleared.
  - Stalled: stay in REQ. Stall time does not count toward TIMEOUT.
- WAIT: o_wb_stb=0; the timeout counter increments each cycle.
  - i_wb_ack=1: capture {addr, i_wb_data} into o_word_data and go to PUSH.
  - Counter reaches TIMEOUT with no ack: set o_timeout_err=1 and o_err_addr=addr, emit no word, and advance to the next address.
- PUSH: o_word_valid=1, o_word_data held. On i_word_ready=1, drop valid and advance.
- Advance: if addr==NUM_CH-1, go to DONE; otherwise addr+1 and go to REQ.
- DONE: pulse o_sweep_done for one cycle, then go to IDLE. o_busy is low in that cycle.
- i_wb_ack outside REQ/WAIT is ignored. A second ack in WAIT after the first is ignored.
- Simultaneous events:
  - i_err_clr and a new timeout in the same cycle: the timeout wins (flag set, new address).
  - Multiple timeouts in one sweep: o_err_addr holds the latest.
- The address counter never wraps within a sweep. Data width is passed through unmodified, with no arithmetic on data.

## Timing
- Accepted i_start at edge 0: o_busy=1 and o_wb_stb=1 with addr 0 after edge 1.
- Zero-stall slave with ack one cycle after stb: stb high 1 cycle, WAIT 1 cycle, o_word_valid high the cycle after the ack edge.
- With i_word_ready tied high, each word takes 3 cycles: REQ, WAIT, PUSH.
- Ack in the same cycle as stb acceptance: 2 cycles per word.
- Timeout path: after acceptance, the counter reaches TIMEOUT after TIMEOUT cycles in WAIT. The error flag is visible the next cycle, and stb for the next address rises in that same cycle.
- o_sweep_done rises one cycle after the last word handshake (or the last timeout).
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Nominal sweep: slave acks 1 cycle after stb, data = 0x200|addr, ready=1 -> 12 words {0x0,0x200}..{0xB,0x20B} in order, o_sweep_done pulse, o_timeout_err=0, 36 cycles from start to done.
- Stall: hold i_wb_stall=1 for 5 cycles on addr 3 -> o_wb_stb and o_wb_addr=3 stay stable for 6 cycles, no timeout, word {0x3,data} emitted once.
- Timeout: slave never acks addr 7, TIMEOUT=15 -> no word for addr 7, o_timeout_err=1, o_err_addr=7, sweep continues to addr 8 and completes with 11 words.
- Backpressure: i_word_ready=0 for 4 cycles on addr 0 -> o_word_valid and o_word_data={0x0,data} held, no stb issued until ready, no word lost or duplicated.
- Reset mid-sweep: drop rst_n during WAIT on addr 5 -> all outputs 0 asynchronously; after release, idle until i_start; the new sweep starts at addr 0.
- Start while busy plus error clear: i_start at addr 4 is ignored (only 12 words total); i_err_clr after a timeout clears the flag and o_err_addr to 0.
